// File: rtl/nmi_arb.sv
// Round-robin arbiter sharing one native memory port between NUM_MSTR masters, with a hung-slave watchdog.
// Grant one cycle after a request, ready passes straight through from the slave, one idle cycle between grants.
module nmi_arb #(
  parameter int          NUM_MSTR       = 2,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF,
  localparam int         IW             = (NUM_MSTR > 1) ? $clog2(NUM_MSTR) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_MSTR-1:0]       mst_valid_i,
  input  logic [NUM_MSTR-1:0][31:0] mst_addr_i,
  input  logic [NUM_MSTR-1:0][31:0] mst_wdata_i,
  input  logic [NUM_MSTR-1:0][3:0]  mst_wstrb_i,
  output logic [NUM_MSTR-1:0]       mst_ready_o,
  output logic [31:0]               mst_rdata_o,
  output logic                      slv_valid_o,
  output logic [31:0]               slv_addr_o,
  output logic [31:0]               slv_wdata_o,
  output logic [3:0]                slv_wstrb_o,
  input  logic [31:0]               slv_rdata_i,
  input  logic                      slv_ready_i,
  output logic [NUM_MSTR-1:0]       gnt_o,
  output logic                      busy_o,
  output logic                      err_o,
  output logic                      err_sticky_o,
  output logic [IW-1:0]             err_id_o,
  input  logic                      err_clr_i
);

  localparam int            WW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WW-1:0] WDOG_LAST = (TIMEOUT_CYCLES > 0) ? WW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [IW-1:0] LAST_RST  = IW'(NUM_MSTR - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] gnt_idx_q, gnt_idx_d;
  logic [IW-1:0] last_idx_q, last_idx_d;
  logic [IW-1:0] err_id_q, err_id_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          err_sticky_q, err_sticky_d;

  logic          busy, done, timeout, cpl;
  logic          found;
  logic [IW-1:0] pick;
  int            idx;

  assign busy    = (state_q == BUSY);
  assign done    = busy && slv_ready_i;
  assign timeout = (TIMEOUT_CYCLES > 0) && busy && !slv_ready_i && (wdog_q == WDOG_LAST);
  // A reset cycle suppresses completion so an aborted transfer never sees ready.
  assign cpl     = (done || timeout) && !rst_i;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_MSTR; k++) begin
      idx = int'(last_idx_q) + k;
      if (idx >= NUM_MSTR) idx = idx - NUM_MSTR;
      if (!found && mst_valid_i[IW'(idx)]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    gnt_idx_d    = gnt_idx_q;
    last_idx_d   = last_idx_q;
    wdog_d       = wdog_q;
    err_id_d     = err_id_q;
    err_sticky_d = err_clr_i ? 1'b0 : err_sticky_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_idx_d = pick;
          wdog_d    = '0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (done || timeout) begin
          state_d    = IDLE;
          last_idx_d = gnt_idx_q;
          wdog_d     = '0;
        end else if (TIMEOUT_CYCLES > 0) begin
          wdog_d = wdog_q + 1'b1;
        end
        if (timeout) begin
          err_sticky_d = 1'b1;
          err_id_d     = gnt_idx_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mst_ready_o = '0;
    gnt_o       = '0;
    mst_rdata_o = '0;
    slv_addr_o  = '0;
    slv_wdata_o = '0;
    slv_wstrb_o = '0;
    if (cpl) begin
      mst_ready_o[gnt_idx_q] = 1'b1;
      mst_rdata_o            = done ? slv_rdata_i : ERR_RDATA;
    end
    if (busy) begin
      gnt_o[gnt_idx_q] = 1'b1;
      slv_addr_o       = mst_addr_i[gnt_idx_q];
      slv_wdata_o      = mst_wdata_i[gnt_idx_q];
      slv_wstrb_o      = mst_wstrb_i[gnt_idx_q];
    end
  end

  assign slv_valid_o  = busy;
  assign busy_o       = busy;
  assign err_o        = timeout && !rst_i;
  assign err_sticky_o = err_sticky_q;
  assign err_id_o     = err_id_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      gnt_idx_q    <= '0;
      last_idx_q   <= LAST_RST;
      wdog_q       <= '0;
      err_sticky_q <= 1'b0;
      err_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      gnt_idx_q    <= gnt_idx_d;
      last_idx_q   <= last_idx_d;
      wdog_q       <= wdog_d;
      err_sticky_q <= err_sticky_d;
      err_id_q     <= err_id_d;
    end
  end

endmodule

// File: tb/tb_nmi_arb.sv
// Bench for nmi_arb: four masters, 8-cycle watchdog, table of transactions plus corner-case sequences.
module tb_nmi_arb;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       mst_valid;
  logic [3:0][31:0] mst_addr;
  logic [3:0][31:0] mst_wdata;
  logic [3:0][3:0]  mst_wstrb;
  logic [3:0]       mst_ready;
  logic [31:0]      mst_rdata;
  logic             slv_valid;
  logic [31:0]      slv_addr, slv_wdata;
  logic [3:0]       slv_wstrb;
  logic [31:0]      slv_rdata;
  logic             slv_ready;
  logic [3:0]       gnt;
  logic             busy, err, err_sticky, err_clr;
  logic [1:0]       err_id;

  int total = 0;
  int bad   = 0;

  typedef struct { int gnt; logic [31:0] rdata; bit err; } exp_t;
  typedef struct { logic [3:0] vm; int lat; logic [31:0] srd; int eg; logic [31:0] erd; bit eerr; } vec_t;

  exp_t sb[$];
  vec_t tbl[9];

  always #5 clk = ~clk;

  nmi_arb #(.NUM_MSTR(4), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .mst_valid_i(mst_valid), .mst_addr_i(mst_addr), .mst_wdata_i(mst_wdata), .mst_wstrb_i(mst_wstrb),
    .mst_ready_o(mst_ready), .mst_rdata_o(mst_rdata),
    .slv_valid_o(slv_valid), .slv_addr_o(slv_addr), .slv_wdata_o(slv_wdata), .slv_wstrb_o(slv_wstrb),
    .slv_rdata_i(slv_rdata), .slv_ready_i(slv_ready),
    .gnt_o(gnt), .busy_o(busy), .err_o(err), .err_sticky_o(err_sticky), .err_id_o(err_id),
    .err_clr_i(err_clr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Starts in an IDLE cycle just after a negedge; returns in the following IDLE (bubble) cycle.
  // lat = BUSY cycle in which the slave answers, 0 = never.
  task automatic run_txn(input logic [3:0] vm, input int lat, input logic [31:0] srd, input int eg,
                         input logic [31:0] erd, input bit eerr, input bit clr_last, input bit drop);
    int   k;
    bit   done;
    exp_t e;
    e.gnt = eg; e.rdata = erd; e.err = eerr;
    sb.push_back(e);
    mst_valid = vm;
    #1;
    chk("idle_valid", {31'd0, slv_valid}, 32'd0);
    chk("idle_gnt", {28'd0, gnt}, 32'd0);
    @(negedge clk);
    k = 0;
    done = 1'b0;
    while (!done && k < 12) begin
      k++;
      if (k == 1) begin
        chk("gnt", {28'd0, gnt}, 32'd1 << eg);
        chk("busy", {31'd0, busy}, 32'd1);
        chk("slv_addr", slv_addr, 32'h0400_0010 + 32'(eg) * 32'h100);
        chk("slv_wdata", slv_wdata, 32'hA000_0000 + 32'(eg));
        chk("slv_wstrb", {28'd0, slv_wstrb}, (eg % 2 == 1) ? 32'hF : 32'h0);
      end
      slv_ready = (lat == k);
      slv_rdata = srd;
      err_clr   = clr_last && (k == 8);
      if (drop && k == 2) mst_valid[eg] = 1'b0;
      #1;
      chk("busy_valid", {31'd0, slv_valid}, 32'd1);
      if (mst_ready != 4'd0) begin
        done = 1'b1;
        chk("cpl_cycle", k, (lat == 0) ? 8 : lat);
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_underflow: ready %b with nothing expected", mst_ready);
        end else begin
          e = sb.pop_front();
          chk("ready_onehot", {28'd0, mst_ready}, 32'd1 << e.gnt);
          chk("rdata", mst_rdata, e.rdata);
          chk("err_pulse", {31'd0, err}, {31'd0, e.err});
        end
      end
      @(negedge clk);
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL txn_hang: no ready within %0d cycles, want master %0d", k, eg);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    slv_ready = 1'b0;
    err_clr   = 1'b0;
    mst_valid = '0;
    #1;
    chk("bubble_valid", {31'd0, slv_valid}, 32'd0);
    chk("bubble_ready", {28'd0, mst_ready}, 32'd0);
    chk("bubble_err", {31'd0, err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    tbl[0] = '{4'b0001, 3, 32'h1234_5678, 0, 32'h1234_5678, 1'b0};
    tbl[1] = '{4'b0011, 1, 32'h1111_0001, 1, 32'h1111_0001, 1'b0};
    tbl[2] = '{4'b0011, 2, 32'h2222_0002, 0, 32'h2222_0002, 1'b0};
    tbl[3] = '{4'b0011, 1, 32'h3333_0003, 1, 32'h3333_0003, 1'b0};
    tbl[4] = '{4'b1010, 2, 32'h4444_0004, 3, 32'h4444_0004, 1'b0};
    tbl[5] = '{4'b1010, 1, 32'h5555_0005, 1, 32'h5555_0005, 1'b0};
    tbl[6] = '{4'b0100, 0, 32'h6666_0006, 2, 32'hDEAD_BEEF, 1'b1};
    tbl[7] = '{4'b1001, 8, 32'h7777_0007, 3, 32'h7777_0007, 1'b0};
    tbl[8] = '{4'b1111, 2, 32'h8888_0008, 0, 32'h8888_0008, 1'b0};

    for (int i = 0; i < 4; i++) begin
      mst_addr[i]  = 32'h0400_0010 + 32'(i) * 32'h100;
      mst_wdata[i] = 32'hA000_0000 + 32'(i);
      mst_wstrb[i] = (i % 2 == 1) ? 4'hF : 4'h0;
    end
    rst = 1'b1; mst_valid = '0; slv_ready = 1'b0; slv_rdata = '0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", {31'd0, slv_valid}, 32'd0);
    chk("rst_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sticky", {31'd0, err_sticky}, 32'd0);
    chk("rst_err_id", {30'd0, err_id}, 32'd0);
    chk("rst_ready", {28'd0, mst_ready}, 32'd0);

    for (int i = 0; i < 9; i++)
      run_txn(tbl[i].vm, tbl[i].lat, tbl[i].srd, tbl[i].eg, tbl[i].erd, tbl[i].eerr, 1'b0, 1'b0);

    chk("sticky_set", {31'd0, err_sticky}, 32'd1);
    chk("err_id_set", {30'd0, err_id}, 32'd2);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    chk("sticky_clr", {31'd0, err_sticky}, 32'd0);
    chk("err_id_kept", {30'd0, err_id}, 32'd2);

    // Granted master withdraws its request mid-transfer; the grant and ready pulse must survive.
    run_txn(4'b0010, 3, 32'hABCD_0001, 1, 32'hABCD_0001, 1'b0, 1'b0, 1'b1);

    // Clear and timeout in the same cycle: the flag must stay set.
    run_txn(4'b0010, 0, 32'h9999_0009, 1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
    chk("set_wins", {31'd0, err_sticky}, 32'd1);
    chk("err_id_1", {30'd0, err_id}, 32'd1);

    slv_ready = 1'b1;
    slv_rdata = 32'hCAFE_F00D;
    #1;
    chk("idle_rdy_ready", {28'd0, mst_ready}, 32'd0);
    chk("idle_rdy_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    slv_ready = 1'b0;
    #1;
    chk("idle_rdy_after", {31'd0, slv_valid}, 32'd0);

    mst_valid = 4'b0100;
    @(negedge clk);
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_valid", {31'd0, slv_valid}, 32'd0);
    chk("abort_gnt", {28'd0, gnt}, 32'd0);
    chk("abort_ready", {28'd0, mst_ready}, 32'd0);
    chk("abort_addr", slv_addr, 32'd0);
    chk("abort_sticky", {31'd0, err_sticky}, 32'd0);
    chk("abort_err_id", {30'd0, err_id}, 32'd0);
    rst = 1'b0;
    run_txn(4'b1111, 2, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0);

    chk("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nmi_arb.md
# nmi_arb

Round-robin arbiter that shares one native memory interface (valid/ready/addr/wdata/wstrb/rdata, PicoRV32-style) between NUM_MSTR requesters. It sits between several bus masters (core, DMA, debug) and a single slave port such as the psram, spisd or i2s interface behind the bus. It holds each grant until the slave completes. A watchdog terminates hung transactions with an error response so no master stalls forever.

## Interface
- NUM_MSTR, 2: number of requesting masters, 2..8; IW = max(1, $clog2(NUM_MSTR)).
- TIMEOUT_CYCLES, 1024: cycles a granted transaction may wait for slv_ready_i; 0 disables the watchdog.
- ERR_RDATA, 32'hDEAD_BEEF: read data returned on timeout.

Ports:
- clk_i  in  1  single clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- mst_valid_i  in  [NUM_MSTR-1:0]  per-master request; held high until that master's ready.
- mst_addr_i  in  [NUM_MSTR-1:0][31:0]  per-master address.
- mst_wdata_i  in  [NUM_MSTR-1:0][31:0]  per-master write data.
- mst_wstrb_i  in  [NUM_MSTR-1:0][3:0]  per-master byte strobes; 0 means read.
- mst_ready_o  out  [NUM_MSTR-1:0]  one-cycle completion pulse to the granted master only.
- mst_rdata_o  out  32  shared read data; valid only when some mst_ready_o bit is high.
- slv_valid_o  out  1  request to the shared slave.
- slv_addr_o / slv_wdata_o  out  32  granted master's address and write data; 0 when slv_valid_o is low.
- slv_wstrb_o  out  4  granted master's strobes; 0 when slv_valid_o is low.
- slv_rdata_i  in  32  slave read data.
- slv_ready_i  in  1  slave completion pulse.
- gnt_o  out  [NUM_MSTR-1:0]  one-hot current grant; 0 when idle.
- busy_o  out  1  a transaction is in flight.
- err_o  out  1  one-cycle pulse on timeout.
- err_sticky_o  out  1  set by timeout, cleared by err_clr_i.
- err_id_o  out  IW  master index of the most recent timeout.
- err_clr_i  in  1  clears err_sticky_o.

## Operation
- States: IDLE, BUSY. Registers: gnt_idx (IW), last_idx (IW), wdog counter (wide enough for TIMEOUT_CYCLES), err_sticky, err_id.
- IDLE: if any mst_valid_i is set, pick the first set bit searching from (last_idx+1) mod NUM_MSTR upward with wrap. Register it into gnt_idx and go to BUSY. With no request, stay in IDLE.
- BUSY:
  - slv_valid_o = 1 and gnt_o = onehot(gnt_idx).
  - slv_addr/wdata/wstrb are a combinational mux of master gnt_idx's inputs.
- Normal completion: slv_ready_i=1 in BUSY makes mst_ready_o[gnt_idx]=1 and mst_rdata_o=slv_rdata_i in the same cycle. Next state is IDLE, last_idx<=gnt_idx, wdog<=0.
- Timeout (TIMEOUT_CYCLES>0): wdog increments each BUSY cycle. In the BUSY cycle where wdog==TIMEOUT_CYCLES-1 and slv_ready_i=0:
  - mst_ready_o[gnt_idx]=1, mst_rdata_o=ERR_RDATA, err_o=1;
  - slv_valid_o drops next cycle and the state returns to IDLE;
  - err_sticky<=1, err_id<=gnt_idx, last_idx<=gnt_idx.
- slv_ready_i in the timeout cycle counts as normal completion: no error.
- slv_ready_i while IDLE is ignored: no mst_ready_o, no state change.
- Granted master dropping mst_valid_i mid-transaction (illegal): the grant is held and the transaction completes normally. The ready pulse is still emitted.
- err_clr_i and a timeout in the same cycle: the set wins.
- Reset (also mid-transaction):
  - state=IDLE, last_idx=NUM_MSTR-1 (so master 0 wins first), gnt_idx=0, wdog=0, err_sticky=0, err_id=0.
  - All outputs 0.
  - An aborted transaction receives no ready pulse.

## Timing
- Request seen in IDLE at cycle t -> slv_valid_o high at t+1.
- Slave ready at cycle r -> master ready at r (combinational pass-through), IDLE at r+1.
- The next slv_valid_o is high at r+2 earliest: one mandatory bubble between transactions.
- Timeout response is issued in the TIMEOUT_CYCLES-th cycle of slv_valid_o.
- Combinational paths: slv_ready_i->mst_ready_o, slv_rdata_i->mst_rdata_o, mst_*_i->slv_*_o. No path from mst_valid_i to any output.

## Test plan
- Single master 0 read: addr 0x0400_0010, slave ready at the 3rd valid cycle with rdata 0x1234_5678 -> slv_valid_o 3 cycles, mst_ready_o=2'b01 for 1 cycle with rdata 0x1234_5678.
- Both masters request continuously from reset with NUM_MSTR=2 -> grant order 0,1,0,1 with one idle cycle between grants; writes forward wstrb 4'hF and wdata unchanged.
- NUM_MSTR=4, masters 1 and 3 requesting, last_idx=1 -> 3 is granted before 1; then 1.
- TIMEOUT_CYCLES=8, slave never ready:
  - ready pulse in the 8th BUSY cycle with rdata 0xDEAD_BEEF;
  - err_o one cycle, err_sticky_o=1, err_id_o=granted index;
  - err_clr_i clears the sticky flag;
  - slave ready in the 8th cycle instead -> normal data, no error.
- rst_i asserted during BUSY -> next cycle all outputs 0 and no ready pulse. The first request after reset is served normally and master 0 wins a tie.
- slv_ready_i pulsed while IDLE -> no mst_ready_o and no state change.
